// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and constants for the sequential Baugh-Wooley multiplier
package mul_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Correction constant 2^w + 2^(2w-1); callers truncate to 2*w bits.
    function automatic logic [63:0] bw_const(input int w);
        return (64'd1 << w) | (64'd1 << (2 * w - 1));
    endfunction

endpackage

// File: rtl/mul_pp_row.sv
// rtl/mul_pp_row.sv - one Baugh-Wooley partial-product row (AND/NAND cells)
module mul_pp_row #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] xr,
    input  logic             ybit,
    input  logic             last_row,
    output logic [WIDTH-1:0] pp
);

    logic [WIDTH-1:0] and_row;
    logic [WIDTH-1:0] nand_mask;

    assign and_row   = xr & {WIDTH{ybit}};
    // Sign column is NANDed on ordinary rows; the last row NANDs every other column instead.
    assign nand_mask = {~last_row, {(WIDTH-1){last_row}}};
    assign pp        = and_row ^ nand_mask;

endmodule

// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - sequential signed multiplier: one partial-product row per cycle
module mul_seq_ctrl
    import mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [PW-1:0] ACC_INIT = PW'(bw_const(WIDTH));
    localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] xr;
    logic [WIDTH-1:0] yr;
    logic [PW-1:0]    acc;
    logic [WIDTH-1:0] pp;
    logic [PW-1:0]    row;
    logic [PW-1:0]    acc_next;
    logic             accept;
    logic             last_row;

    assign last_row = (count == LAST);

    mul_pp_row #(.WIDTH(WIDTH)) u_pp_row (
        .xr       (xr),
        .ybit     (yr[count]),
        .last_row (last_row),
        .pp       (pp)
    );

    assign row      = {{WIDTH{1'b0}}, pp} << count;
    assign acc_next = acc + row;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_row) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xr      <= '0;
            yr      <= '0;
            count   <= '0;
            acc     <= '0;
            product <= '0;
        end else if (accept) begin
            xr    <= x;
            yr    <= y;
            count <= '0;
            acc   <= ACC_INIT;
        end else if (state == RUN) begin
            acc <= acc_next;
            // Counter stops at the last row so it never wraps.
            if (last_row) begin
                product <= acc_next;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb/tb_mul_seq_ctrl.sv - scoreboard bench for mul_seq_ctrl against an arithmetic reference
module tb_mul_seq_ctrl;

    localparam int W = 8;

    typedef struct {
        logic [2*W-1:0] prod;
        int             due;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   x = '0;
    logic [W-1:0]   y = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int             checks = 0;
    int             errors = 0;
    int             cyc = 0;
    int             n_acc = 0;
    exp_t           q[$];
    logic [2*W-1:0] last_prod = '0;
    logic           e_done;
    logic           e_busy;

    logic [W-1:0]   dir_x [5] = '{8'd3, 8'hFF, 8'h80, 8'h80, 8'h00};
    logic [W-1:0]   dir_y [5] = '{8'd5, 8'hFF, 8'h80, 8'h7F, 8'hB3};
    logic [2*W-1:0] dir_p [5] = '{16'h000F, 16'h0001, 16'h4000, 16'hC080, 16'h0000};

    mul_seq_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .x       (x),
        .y       (y),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Drive one clock of stimulus; the model accepts start only when no operation is outstanding.
    task automatic step(input logic s, input logic [W-1:0] xv, input logic [W-1:0] yv);
        logic                  idle;
        logic signed [2*W-1:0] p;
        exp_t                  e;
        start = s;
        x     = xv;
        y     = yv;
        @(negedge clk);
        #1;
        idle = (q.size() == 0);
        @(posedge clk);
        #1;
        if (s && idle) begin
            p      = $signed(xv) * $signed(yv);
            e.prod = p;
            e.due  = cyc + W;
            q.push_back(e);
            n_acc++;
        end
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, W'($urandom), W'($urandom));
    endtask

    // Monitor: every cycle compares done/busy/product with the outstanding-operation queue.
    initial begin
        forever begin
            @(negedge clk);
            e_done = (q.size() > 0) && (q[0].due == cyc);
            e_busy = (q.size() > 0) && (q[0].due > cyc);
            check("done", done, e_done);
            check("busy", busy, e_busy);
            if (done && busy) check("done_busy_overlap", 1, 0);
            if (e_done) begin
                check("product", product, q[0].prod);
                last_prod = q[0].prod;
                void'(q.pop_front());
            end else begin
                check("product_hold", product, last_prod);
            end
        end
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: stuck at cycle %0d, expected completion", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_product", product, 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            step(1'b1, dir_x[i], dir_y[i]);
            idle_steps(W + 1);
            check("spec_vector", product, dir_p[i]);
        end

        for (int i = 0; i < 40; i++) step(1'b1, W'($urandom), W'($urandom));
        idle_steps(W + 2);

        step(1'b1, 8'd100, 8'h9C);
        idle_steps(3);
        #2;
        rst = 1'b1;
        q.delete();
        last_prod = '0;
        #1;
        check("midrun_reset_busy", busy, 0);
        check("midrun_reset_done", done, 0);
        check("midrun_reset_product", product, 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        idle_steps(W + 2);
        step(1'b1, 8'h80, 8'h80);
        idle_steps(W + 1);
        check("after_reset_vector", product, 16'h4000);

        while (n_acc < 1100) step($urandom_range(0, 3) != 0, W'($urandom), W'($urandom));
        idle_steps(W + 2);
        check("queue_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
